instr_mem_loader: RTL and testbench

- Write-side companion to the byte-addressable, little-endian instruction memory read by the fetch unit.
- Accepts 32-bit instruction words over a valid/ready stream from a boot/debug source.
- Serialises each word into four byte writes: LSB at the lowest address.
- Tracks a word-aligned write pointer, flags out-of-range or misaligned loads, and signals completion so the fetch path can be released from reset.

---
 rtl/instr_mem_pkg.sv | 19 +
 rtl/instr_mem_loader_if.sv | 23 ++
 rtl/instr_word_serializer.sv | 64 ++++++
 rtl/instr_mem_loader.sv | 110 +++++++++++
 tb/tb_instr_mem_loader.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the instruction-memory loader.
package instr_mem_pkg;

    // Loader session states.
    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        WRITE,
        DONE,
        ERR
    } load_state_t;

    localparam int BYTES_PER_WORD    = 4;
    localparam int DEFAULT_MEM_BYTES = 36;

    // Selects one byte lane of a 32-bit instruction word.
    typedef logic [1:0] lane_t;

endpackage

// File: rtl/instr_mem_loader_if.sv
// Word stream from the boot/debug source plus the byte-write bus to the
// instruction memory. The loader sits on the slave side.
interface instr_mem_loader_if #(
    parameter int ADDR_W = 32
) ();
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_word;
    logic              in_last;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;

    modport master (
        output in_valid, in_word, in_last,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_word, in_last,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_word_serializer.sv
// Turns one 32-bit word into four consecutive byte writes, LSB first at
// the lowest address. The first byte appears the cycle after load.
module instr_word_serializer
    import instr_mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       word,
    input  logic [ADDR_W-1:0] ptr,
    input  logic              load,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              last_byte
);

    logic [31:0] word_reg;
    lane_t       lane_reg;
    lane_t       lane_next;
    logic        active_reg;
    logic [7:0]  lane_bytes [BYTES_PER_WORD];

    genvar gi;
    generate
        for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
            assign lane_bytes[gi] = word_reg[8*gi +: 8];
        end
    endgenerate

    assign lane_next = lane_reg + lane_t'(1);
    assign last_byte = active_reg && (lane_reg == lane_t'(BYTES_PER_WORD - 1));

    // Byte sequencer: latch the word on load, then step lane and address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_reg   <= '0;
            lane_reg   <= '0;
            active_reg <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else if (load) begin
            word_reg   <= word;
            lane_reg   <= '0;
            active_reg <= 1'b1;
            mem_we     <= 1'b1;
            mem_addr   <= ptr;
            mem_wdata  <= word[7:0];
        end else if (active_reg) begin
            if (last_byte) begin
                // Address and data hold their last values while idle.
                active_reg <= 1'b0;
                mem_we     <= 1'b0;
            end else begin
                lane_reg   <= lane_next;
                mem_addr   <= mem_addr + ADDR_W'(1);
                mem_wdata  <= lane_bytes[lane_next];
            end
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Loads instruction words into byte-addressed instruction memory, checking
// alignment and range, and pulses done when the final word is written.
module instr_mem_loader
    import instr_mem_pkg::*;
#(
    parameter int MEM_BYTES = DEFAULT_MEM_BYTES,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    instr_mem_loader_if.slave bus,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] words_loaded
);

    load_state_t       state_reg, state_next;
    logic [ADDR_W-1:0] ptr_reg;
    logic [ADDR_W-1:0] words_reg;
    logic              last_reg;
    logic              in_ready_reg, busy_reg, done_reg, error_reg;

    logic idle_like, start_ok, misaligned, handshake, out_of_range;
    logic load, last_byte, word_done;

    assign idle_like    = (state_reg == IDLE) || (state_reg == DONE) || (state_reg == ERR);
    assign start_ok     = start && idle_like;
    assign misaligned   = (base_addr[1:0] != 2'b00);
    assign handshake    = (state_reg == ACCEPT) && in_ready_reg && bus.in_valid;
    // Compared without forming ptr+3 so a pointer near the top of the
    // address space cannot wrap around and pass the check.
    assign out_of_range = (ptr_reg > ADDR_W'(MEM_BYTES - BYTES_PER_WORD));
    assign load         = handshake && !out_of_range;
    assign word_done    = (state_reg == WRITE) && last_byte;

    instr_word_serializer #(
        .ADDR_W (ADDR_W)
    ) u_serializer (
        .clk       (clk),
        .reset     (reset),
        .word      (bus.in_word),
        .ptr       (ptr_reg),
        .load      (load),
        .mem_we    (bus.mem_we),
        .mem_addr  (bus.mem_addr),
        .mem_wdata (bus.mem_wdata),
        .last_byte (last_byte)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next-state decode.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE, ERR: if (start) state_next = misaligned ? ERR : ACCEPT;
            ACCEPT:          if (handshake) state_next = out_of_range ? ERR : WRITE;
            WRITE:           if (last_byte) state_next = last_reg ? DONE : ACCEPT;
            default:         state_next = IDLE;
        endcase
    end

    // Registered status outputs, pointer and word counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_reg      <= '0;
            words_reg    <= '0;
            last_reg     <= 1'b0;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            error_reg    <= 1'b0;
        end else begin
            in_ready_reg <= (state_next == ACCEPT);
            busy_reg     <= (state_next == ACCEPT) || (state_next == WRITE);
            done_reg     <= word_done && last_reg;
            if (start_ok) begin
                if (misaligned) begin
                    error_reg <= 1'b1;
                end else begin
                    ptr_reg   <= base_addr;
                    words_reg <= '0;
                    error_reg <= 1'b0;
                end
            end
            if (handshake) begin
                last_reg <= bus.in_last;
                if (out_of_range) error_reg <= 1'b1;
            end
            if (word_done) begin
                ptr_reg   <= ptr_reg + ADDR_W'(BYTES_PER_WORD);
                words_reg <= words_reg + ADDR_W'(1);
            end
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign busy          = busy_reg;
    assign done          = done_reg;
    assign error         = error_reg;
    assign words_loaded  = words_reg;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: table of load sessions plus
// hand-written corner sequences, byte writes checked through a scoreboard.
module tb_instr_mem_loader;
    import instr_mem_pkg::*;

    localparam int ADDR_W    = 32;
    localparam int MEM_BYTES = 36;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              busy, done, error;
    logic [ADDR_W-1:0] words_loaded;

    instr_mem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    instr_mem_loader #(
        .MEM_BYTES (MEM_BYTES),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .base_addr    (base_addr),
        .bus          (bus),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    typedef struct {
        logic [31:0] base;
        int          nwords;
        logic        exp_error;
        int          exp_loaded;
        int          exp_done;
    } vec_t;

    wr_t         exp_q [$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          done_cnt = 0;
    logic [31:0] m_ptr = '0;
    logic [31:0] prog [5];
    vec_t        vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every byte write must match the oldest expected write.
    always @(negedge clk) begin
        wr_t e;
        if (done) done_cnt++;
        if (bus.mem_we) begin
            $display("write addr=%0d data=%02h", bus.mem_addr, bus.mem_wdata);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL spurious_write: got addr=%0d data=%02h expected no write",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", bus.mem_addr, e.addr);
                chk("wr_data", 32'(bus.mem_wdata), 32'(e.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] a);
        start = 1'b1;
        base_addr = a;
        tick();
        start = 1'b0;
        if (a[1:0] == 2'b00) m_ptr = a;
    endtask

    // Offers one word; returns one cycle after the handshake edge.
    task automatic offer(input logic [31:0] w, input logic last, output bit in_range);
        int waited;
        waited = 0;
        in_range = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_word = w;
        bus.in_last = last;
        while (!bus.in_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!bus.in_ready) begin
            chk("ready_timeout", 32'(bus.in_ready), 32'd1);
        end else begin
            in_range = (m_ptr <= 32'(MEM_BYTES - 4));
            if (in_range) begin
                for (int b = 0; b < 4; b++) exp_q.push_back({m_ptr + 32'(b), w[8*b +: 8]});
                m_ptr = m_ptr + 32'd4;
            end
            $display("word %h last=%0d in_range=%0d", w, last, in_range);
            tick();
        end
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
    endtask

    task automatic run_vector(input vec_t v);
        bit ok;
        int done_before;
        done_before = done_cnt;
        do_start(v.base);
        chk("start_ready", 32'(bus.in_ready), 32'd1);
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_err_clr", 32'(error), 32'd0);
        for (int i = 0; i < v.nwords; i++) begin
            offer(prog[i], i == v.nwords - 1, ok);
            if (!ok) begin
                chk("ovf_error", 32'(error), 32'd1);
                chk("ovf_ready", 32'(bus.in_ready), 32'd0);
                chk("ovf_busy", 32'(busy), 32'd0);
                break;
            end
            repeat (4) tick();
            if (i == v.nwords - 1) begin
                chk("done_pulse", 32'(done), 32'd1);
                chk("done_busy", 32'(busy), 32'd0);
                tick();
                chk("done_one_cycle", 32'(done), 32'd0);
            end else begin
                chk("next_ready", 32'(bus.in_ready), 32'd1);
            end
        end
        repeat (2) tick();
        chk("words_loaded", words_loaded, 32'(v.exp_loaded));
        chk("error_final", 32'(error), 32'(v.exp_error));
        chk("done_count", 32'(done_cnt - done_before), 32'(v.exp_done));
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        prog[0] = 32'hFC000001;
        prog[1] = 32'h00011020;
        prog[2] = 32'h01095024;
        prog[3] = 32'h01660180;
        prog[4] = 32'h01285025;
        vecs[0] = '{base: 32'd0,  nwords: 1, exp_error: 1'b0, exp_loaded: 1, exp_done: 1};
        vecs[1] = '{base: 32'd0,  nwords: 5, exp_error: 1'b0, exp_loaded: 5, exp_done: 1};
        vecs[2] = '{base: 32'd32, nwords: 2, exp_error: 1'b1, exp_loaded: 1, exp_done: 0};
        vecs[3] = '{base: 32'd8,  nwords: 3, exp_error: 1'b0, exp_loaded: 3, exp_done: 1};
        vecs[4] = '{base: 32'd24, nwords: 3, exp_error: 1'b0, exp_loaded: 3, exp_done: 1};
        bus.in_valid = 1'b0;
        bus.in_word = '0;
        bus.in_last = 1'b0;

        // Reset state.
        #3 reset = 1'b0;
        #1;
        chk("rst_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_we", 32'(bus.mem_we), 32'd0);
        chk("rst_addr", bus.mem_addr, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_words", words_loaded, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            $display("vector %0d base=%0d words=%0d", i, vecs[i].base, vecs[i].nwords);
            run_vector(vecs[i]);
        end

        // Misaligned base: error at once, nothing accepted.
        do_start(32'd2);
        chk("mis_error", 32'(error), 32'd1);
        chk("mis_ready", 32'(bus.in_ready), 32'd0);
        chk("mis_busy", 32'(busy), 32'd0);
        bus.in_valid = 1'b1;
        repeat (3) tick();
        bus.in_valid = 1'b0;
        chk("mis_ready_hold", 32'(bus.in_ready), 32'd0);
        chk("mis_error_hold", 32'(error), 32'd1);

        // Backpressure gap and a start pulse during WRITE.
        do_start(32'd4);
        offer(prog[0], 1'b0, ok);
        tick();
        start = 1'b1;
        base_addr = 32'd16;
        tick();
        start = 1'b0;
        repeat (2) tick();
        chk("bp_words1", words_loaded, 32'd1);
        chk("bp_ready", 32'(bus.in_ready), 32'd1);
        repeat (3) tick();
        chk("bp_ready_wait", 32'(bus.in_ready), 32'd1);
        chk("bp_busy_wait", 32'(busy), 32'd1);
        offer(prog[1], 1'b1, ok);
        repeat (4) tick();
        chk("bp_done", 32'(done), 32'd1);
        chk("bp_words2", words_loaded, 32'd2);
        chk("bp_queue", 32'(exp_q.size()), 32'd0);

        // Reset after two of four byte writes.
        do_start(32'd0);
        offer(prog[2], 1'b1, ok);
        repeat (2) tick();
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_we", 32'(bus.mem_we), 32'd0);
        chk("mid_rst_addr", bus.mem_addr, 32'd0);
        chk("mid_rst_data", 32'(bus.mem_wdata), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_words", words_loaded, 32'd0);
        chk("mid_rst_popped", 32'(exp_q.size()), 32'd2);
        exp_q.delete();
        tick();
        reset = 1'b1;
        tick();
        do_start(32'd0);
        offer(prog[3], 1'b1, ok);
        repeat (4) tick();
        chk("reload_done", 32'(done), 32'd1);
        chk("reload_words", words_loaded, 32'd1);
        chk("reload_queue", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
